dll_cfg_ctrl: RTL

Configuration sequencer for the UART clock generator `dll_syn`. Arbitrates between two requesters, the host register port (req0) and the auto-baud engine (req1), that want to change the generator's `limit` and `duty`. Validates each request and applies the new pair only at a generator period boundary, so `clk_out` never sees a truncated or glitched period. After applying, it holds off further requests for one full period.

---
 rtl/dll_cfg_if.sv | 38 +++
 rtl/dll_cfg_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dll_cfg_if.sv
// Configuration bus between the requesters / clock generator and dll_cfg_ctrl.
// Carries both request channels (valid/limit/duty/ready), the generator's
// period_end pulse, and the applied limit/duty plus status pulses.
//   slave  : controller side (dll_cfg_ctrl)
//   master : environment side (requesters + generator)
interface dll_cfg_if;
    logic       req0_valid;
    logic [3:0] req0_limit;
    logic [3:0] req0_duty;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_limit;
    logic [3:0] req1_duty;
    logic       req1_ready;
    logic       period_end;
    logic [3:0] limit;
    logic [3:0] duty;
    logic       busy;
    logic       applied;
    logic       forced;
    logic       err;

    modport slave (
        input  req0_valid, req0_limit, req0_duty,
        input  req1_valid, req1_limit, req1_duty,
        input  period_end,
        output req0_ready, req1_ready,
        output limit, duty, busy, applied, forced, err
    );

    modport master (
        output req0_valid, req0_limit, req0_duty,
        output req1_valid, req1_limit, req1_duty,
        output period_end,
        input  req0_ready, req1_ready,
        input  limit, duty, busy, applied, forced, err
    );
endinterface

// File: rtl/dll_cfg_ctrl.sv
// Configuration sequencer for the dll_syn clock generator. Arbitrates two
// requesters (req0 has priority), validates the requested limit/duty pair,
// applies it only on a generator period boundary (or after TIMEOUT cycles),
// then guards one full period before accepting the next request.
// Ports:
//   clk   : system clock, shared with dll_syn
//   reset : synchronous active-low reset
//   bus   : dll_cfg_if.slave (requests, period_end, limit/duty, status pulses)
module dll_cfg_ctrl #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [3:0]  LIMIT_RST = 4'd15,
    parameter logic [3:0]  DUTY_RST  = 4'd7
) (
    input  logic        clk,
    input  logic        reset,
    dll_cfg_if.slave    bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        limit_q, limit_d;
    logic [3:0]        duty_q, duty_d;
    logic [3:0]        stg_limit_q, stg_limit_d;
    logic [3:0]        stg_duty_q, stg_duty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              applied_q, applied_d;
    logic              forced_q, forced_d;
    logic              err_q, err_d;

    logic              req0_ready_c, req1_ready_c;
    logic              sel_valid_c;
    logic [3:0]        sel_limit_c, sel_duty_c;

    // Ready depends only on registered state and req0_valid, never on data.
    assign req0_ready_c = (state_q == S_IDLE);
    assign req1_ready_c = (state_q == S_IDLE) & ~bus.req0_valid;

    // Fixed-priority pick of the request presented this cycle.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_limit_c = bus.req1_limit;
        sel_duty_c  = bus.req1_duty;
        if (bus.req0_valid) begin
            sel_valid_c = 1'b1;
            sel_limit_c = bus.req0_limit;
            sel_duty_c  = bus.req0_duty;
        end else if (bus.req1_valid) begin
            sel_valid_c = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            limit_q     <= LIMIT_RST;
            duty_q      <= DUTY_RST;
            stg_limit_q <= 4'd0;
            stg_duty_q  <= 4'd0;
            cnt_q       <= '0;
            applied_q   <= 1'b0;
            forced_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            duty_q      <= duty_d;
            stg_limit_q <= stg_limit_d;
            stg_duty_q  <= stg_duty_d;
            cnt_q       <= cnt_d;
            applied_q   <= applied_d;
            forced_q    <= forced_d;
            err_q       <= err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        duty_d      = duty_q;
        stg_limit_d = stg_limit_q;
        stg_duty_d  = stg_duty_q;
        cnt_d       = cnt_q;
        applied_d   = 1'b0;
        forced_d    = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // period_end is ignored here, including on the accept edge.
                if (sel_valid_c) begin
                    if ((sel_limit_c == 4'd0) || (sel_duty_c > sel_limit_c)) begin
                        err_d = 1'b1;
                    end else begin
                        stg_limit_d = sel_limit_c;
                        stg_duty_d  = sel_duty_c;
                        cnt_d       = '0;
                        state_d     = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (bus.period_end || (cnt_q == CNT_LAST)) begin
                    limit_d   = stg_limit_q;
                    duty_d    = stg_duty_q;
                    applied_d = 1'b1;
                    forced_d  = ~bus.period_end;
                    cnt_d     = '0;
                    state_d   = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.period_end || (cnt_q == CNT_LAST)) begin
                    forced_d = ~bus.period_end;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.limit      = limit_q;
    assign bus.duty       = duty_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.applied    = applied_q;
    assign bus.forced     = forced_q;
    assign bus.err        = err_q;

endmodule
